// File: rtl/uart_tx.sv
// uart_tx: UART transmitter with a 16x8 FIFO in front of a start/data/parity/stop serialiser.
// Parity mode and stop count are captured when a byte is popped, so register writes
// made mid-frame only affect later frames.
module uart_tx (
  input  logic        mclk,
  input  logic        reset,
  input  logic [15:0] baud_max_cnt,
  input  logic [1:0]  parity_sel,
  input  logic        stop_sel,
  input  logic [7:0]  wr_data,
  input  logic        wr_en,
  output logic        full,
  output logic        empty,
  output logic        busy,
  output logic        overflow,
  output logic        txd
);

  // state   | meaning
  // IDLE    | line high, pop the FIFO head as soon as one is available
  // START   | start bit (low) for one bit period
  // DATA    | 8 data bits, LSB first, from the shift register
  // PARITY  | parity bit, present only when the latched parity mode is non-zero
  // STOP    | 1 or 2 stop bits (high), then back to IDLE
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  logic [7:0]  mem_q [16];
  logic [3:0]  wr_ptr_q, rd_ptr_q;
  logic [4:0]  count_q, count_d;
  logic        full_q, empty_q, ovf_q;
  logic        push, pop;

  state_t      state_q;
  logic [15:0] cnt1_q;
  logic [2:0]  bit_idx_q;
  logic [7:0]  shift_q;
  logic        par_en_q, par_bit_q, stop2_q;
  logic        txd_q;
  logic        bit_tc;
  logic [7:0]  head;

  assign push   = wr_en & ~full_q;
  assign pop    = (state_q == IDLE) & ~empty_q;
  assign head   = mem_q[rd_ptr_q];
  assign bit_tc = (cnt1_q == baud_max_cnt);

  // Occupancy after this edge; push and pop together cancel out.
  always_comb begin
    count_d = count_q;
    if (push && !pop)
      count_d = count_q + 5'd1;
    else if (pop && !push)
      count_d = count_q - 5'd1;
  end

  // FIFO storage: written only on an accepted push, so no reset is needed.
  always_ff @(posedge mclk) begin
    if (push)
      mem_q[wr_ptr_q] <= wr_data;
  end

  // FIFO pointers, count and registered status flags.
  always_ff @(posedge mclk) begin
    if (reset) begin
      wr_ptr_q <= 4'd0;
      rd_ptr_q <= 4'd0;
      count_q  <= 5'd0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      if (push)
        wr_ptr_q <= wr_ptr_q + 4'd1;
      if (pop)
        rd_ptr_q <= rd_ptr_q + 4'd1;
      count_q <= count_d;
      full_q  <= (count_d == 5'd16);
      empty_q <= (count_d == 5'd0);
      ovf_q   <= wr_en & full_q;
    end
  end

  // Frame sequencer with bit timer, bit index and registered line output.
  always_ff @(posedge mclk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt1_q    <= 16'd0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'd0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop2_q   <= 1'b0;
      txd_q     <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          txd_q     <= 1'b1;
          cnt1_q    <= 16'd0;
          bit_idx_q <= 3'd0;
          if (!empty_q) begin
            shift_q  <= head;
            par_en_q <= (parity_sel != 2'd0);
            case (parity_sel)
              2'd1:    par_bit_q <= ^head;
              2'd2:    par_bit_q <= ~(^head);
              default: par_bit_q <= 1'b0;
            endcase
            stop2_q <= stop_sel;
            txd_q   <= 1'b0;
            state_q <= START;
          end
        end
        START: begin
          if (bit_tc) begin
            cnt1_q    <= 16'd0;
            bit_idx_q <= 3'd0;
            txd_q     <= shift_q[0];
            state_q   <= DATA;
          end else begin
            cnt1_q <= cnt1_q + 16'd1;
          end
        end
        DATA: begin
          if (bit_tc) begin
            cnt1_q  <= 16'd0;
            shift_q <= {1'b0, shift_q[7:1]};
            if (bit_idx_q == 3'd7) begin
              bit_idx_q <= 3'd0;
              if (par_en_q) begin
                txd_q   <= par_bit_q;
                state_q <= PARITY;
              end else begin
                txd_q   <= 1'b1;
                state_q <= STOP;
              end
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              txd_q     <= shift_q[1];
            end
          end else begin
            cnt1_q <= cnt1_q + 16'd1;
          end
        end
        PARITY: begin
          if (bit_tc) begin
            cnt1_q    <= 16'd0;
            bit_idx_q <= 3'd0;
            txd_q     <= 1'b1;
            state_q   <= STOP;
          end else begin
            cnt1_q <= cnt1_q + 16'd1;
          end
        end
        STOP: begin
          txd_q <= 1'b1;
          if (bit_tc) begin
            cnt1_q <= 16'd0;
            if (bit_idx_q == {2'b00, stop2_q}) begin
              bit_idx_q <= 3'd0;
              state_q   <= IDLE;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end else begin
            cnt1_q <= cnt1_q + 16'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          txd_q   <= 1'b1;
        end
      endcase
    end
  end

  assign full     = full_q;
  assign empty    = empty_q;
  assign overflow = ovf_q;
  assign busy     = (state_q != IDLE);
  assign txd      = txd_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed frames checked cycle by cycle on the serial line.
module tb_uart_tx;

  logic        mclk;
  logic        reset;
  logic [15:0] baud_max_cnt;
  logic [1:0]  parity_sel;
  logic        stop_sel;
  logic [7:0]  wr_data;
  logic        wr_en;
  logic        full, empty, busy, overflow, txd;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] vec [0:17];

  uart_tx dut (
    .mclk         (mclk),
    .reset        (reset),
    .baud_max_cnt (baud_max_cnt),
    .parity_sel   (parity_sel),
    .stop_sel     (stop_sel),
    .wr_data      (wr_data),
    .wr_en        (wr_en),
    .full         (full),
    .empty        (empty),
    .busy         (busy),
    .overflow     (overflow),
    .txd          (txd)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected line pattern, bit 0 first: start, data LSB first, optional parity, stops (1s).
  function automatic logic [11:0] mk_frame(input logic [7:0] d, input bit pen, input bit pb);
    logic [11:0] f;
    f      = 12'hFFF;
    f[0]   = 1'b0;
    f[8:1] = d;
    if (pen) f[9] = pb;
    return f;
  endfunction

  // Pushes vec[0..n-1] on consecutive cycles; optionally checks full/overflow behaviour.
  task automatic push_seq(input int n, input bit ovf_chk);
    for (int i = 0; i < n; i++) begin
      wr_en   = 1'b1;
      wr_data = vec[i];
      @(negedge mclk);
      if (i == 0) chk("empty_after_push", {31'd0, empty}, 32'd0);
      if (ovf_chk) begin
        chk($sformatf("overflow w%0d", i), {31'd0, overflow}, (i == 17) ? 32'd1 : 32'd0);
        if (i >= 15) chk($sformatf("full w%0d", i), {31'd0, full}, (i >= 16) ? 32'd1 : 32'd0);
      end
    end
    wr_en = 1'b0;
  endtask

  // Waits for the start bit, then checks {busy,txd} on every cycle of the frame and
  // on the single idle cycle that must follow it.
  task automatic frame_chk(input string tag, input logic [11:0] bits, input int nbits,
                           input int bmax, output int waited);
    int limit;
    limit  = (bmax + 1) * 30 + 20;
    waited = 0;
    do begin
      @(negedge mclk);
      waited++;
    end while (txd !== 1'b0 && waited < limit);
    if (txd !== 1'b0) begin
      chk({tag, " start_timeout"}, {31'd0, txd}, 32'd0);
      return;
    end
    for (int b = 0; b < nbits; b++) begin
      for (int c = 0; c <= bmax; c++) begin
        if (!(b == 0 && c == 0)) @(negedge mclk);
        chk($sformatf("%s bit%0d", tag, b), {30'd0, busy, txd}, {30'd0, 1'b1, bits[b]});
      end
    end
    @(negedge mclk);
    chk({tag, " idle"}, {30'd0, busy, txd}, 32'd1);
  endtask

  initial begin
    int w, w2, bad;
    reset        = 1'b1;
    wr_en        = 1'b0;
    wr_data      = 8'h00;
    baud_max_cnt = 16'd3;
    parity_sel   = 2'd0;
    stop_sel     = 1'b0;
    repeat (3) @(negedge mclk);
    chk("rst txd", {31'd0, txd}, 32'd1);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst overflow", {31'd0, overflow}, 32'd0);
    chk("rst full", {31'd0, full}, 32'd0);
    chk("rst empty", {31'd0, empty}, 32'd1);
    reset = 1'b0;
    @(negedge mclk);

    // 0x55, no parity, one stop: 0,1,0,1,... each held 4 cycles
    vec[0] = 8'h55;
    fork
      push_seq(1, 1'b0);
      frame_chk("f55", mk_frame(8'h55, 1'b0, 1'b0), 10, 3, w);
    join
    chk("f55 latency", w, 32'd2);

    // 0xA3 has four ones: even -> 0, odd -> 1, forced -> 0
    vec[0] = 8'hA3;
    parity_sel = 2'd1;
    fork
      push_seq(1, 1'b0);
      frame_chk("a3_even", mk_frame(8'hA3, 1'b1, 1'b0), 11, 3, w);
    join
    parity_sel = 2'd2;
    fork
      push_seq(1, 1'b0);
      frame_chk("a3_odd", mk_frame(8'hA3, 1'b1, 1'b1), 11, 3, w);
    join
    parity_sel = 2'd3;
    fork
      push_seq(1, 1'b0);
      frame_chk("a3_zero", mk_frame(8'hA3, 1'b1, 1'b0), 11, 3, w);
    join

    // 0x00, odd parity -> 1, two stop bits
    vec[0] = 8'h00;
    parity_sel = 2'd2;
    stop_sel   = 1'b1;
    fork
      push_seq(1, 1'b0);
      frame_chk("s2_00", mk_frame(8'h00, 1'b1, 1'b1), 12, 3, w);
    join

    // Config changed mid-frame must not alter this frame (even parity, one stop)
    vec[0] = 8'hA3;
    parity_sel = 2'd1;
    stop_sel   = 1'b0;
    fork
      push_seq(1, 1'b0);
      frame_chk("latched", mk_frame(8'hA3, 1'b1, 1'b0), 11, 3, w);
      begin
        repeat (10) @(negedge mclk);
        parity_sel = 2'd0;
        stop_sel   = 1'b1;
      end
    join
    parity_sel = 2'd0;
    stop_sel   = 1'b0;

    // 18 writes at baud 99: 17 accepted, the 18th dropped, frames back to back
    baud_max_cnt = 16'd99;
    for (int i = 0; i < 18; i++) vec[i] = 8'h30 + 8'(i * 7);
    fork
      push_seq(18, 1'b1);
      begin
        for (int k = 0; k < 17; k++) begin
          frame_chk($sformatf("burst%0d", k), mk_frame(8'h30 + 8'(k * 7), 1'b0, 1'b0), 10, 99, w2);
          if (k > 0) chk($sformatf("burst%0d gap", k), w2, 32'd1);
        end
      end
    join
    chk("burst empty_end", {31'd0, empty}, 32'd1);
    bad = 0;
    repeat (20) begin
      @(negedge mclk);
      if (txd !== 1'b1 || busy !== 1'b0) bad++;
    end
    chk("burst no_extra_frame", bad, 32'd0);

    // baud 0: one cycle per bit, 0xFF then 0x01 with a one-cycle gap
    baud_max_cnt = 16'd0;
    vec[0] = 8'hFF;
    vec[1] = 8'h01;
    fork
      push_seq(2, 1'b0);
      begin
        frame_chk("b0_ff", mk_frame(8'hFF, 1'b0, 1'b0), 10, 0, w);
        chk("b0_ff latency", w, 32'd2);
        frame_chk("b0_01", mk_frame(8'h01, 1'b0, 1'b0), 10, 0, w2);
        chk("b0_01 gap", w2, 32'd1);
      end
    join

    // Reset during DATA with three bytes still queued
    baud_max_cnt = 16'd3;
    vec[0] = 8'h11;
    vec[1] = 8'h22;
    vec[2] = 8'h33;
    vec[3] = 8'h44;
    fork
      push_seq(4, 1'b0);
      begin
        w = 0;
        do begin
          @(negedge mclk);
          w++;
        end while (txd !== 1'b0 && w < 50);
        chk("rstmid start", {31'd0, txd}, 32'd0);
        repeat (6) @(negedge mclk);
      end
    join
    reset = 1'b1;
    @(negedge mclk);
    chk("rstmid txd", {31'd0, txd}, 32'd1);
    chk("rstmid busy", {31'd0, busy}, 32'd0);
    chk("rstmid empty", {31'd0, empty}, 32'd1);
    reset = 1'b0;
    bad = 0;
    repeat (80) begin
      @(negedge mclk);
      if (txd !== 1'b1 || busy !== 1'b0) bad++;
    end
    chk("rstmid quiet", bad, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
